// File: rtl/myproject_div_pkg.sv
// Shared widths, saturation limits and FSM state encoding for the
// sequential signed-by-unsigned divider.
package myproject_div_pkg;

    localparam int DIVIDEND_WIDTH = 26;
    localparam int DIVISOR_WIDTH  = 12;
    localparam int QUOTIENT_WIDTH = 14;
    localparam int CNT_WIDTH      = $clog2(DIVIDEND_WIDTH);

    // Magnitude limits of the signed quotient range.
    localparam int QMAX_MAG = 2 ** (QUOTIENT_WIDTH - 1) - 1;
    localparam int QMIN_MAG = 2 ** (QUOTIENT_WIDTH - 1);

    localparam logic signed [QUOTIENT_WIDTH-1:0] QMAX = QUOTIENT_WIDTH'(QMAX_MAG);
    localparam logic signed [QUOTIENT_WIDTH-1:0] QMIN = QUOTIENT_WIDTH'(QMIN_MAG);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/myproject_sdiv_26s_12ns_14_seq_if.sv
// Operand/result handshake bundle for the divider; slave is the divider side.
interface myproject_sdiv_26s_12ns_14_seq_if;
    import myproject_div_pkg::*;

    logic                               in_valid;
    logic                               in_ready;
    logic signed [DIVIDEND_WIDTH-1:0]   din0;
    logic        [DIVISOR_WIDTH-1:0]    din1;
    logic                               out_valid;
    logic                               out_ready;
    logic signed [QUOTIENT_WIDTH-1:0]   quot;
    logic signed [DIVISOR_WIDTH:0]      rem;
    logic                               dbz;
    logic                               ovf;

    modport master (
        output in_valid, din0, din1, out_ready,
        input  in_ready, out_valid, quot, rem, dbz, ovf
    );

    modport slave (
        input  in_valid, din0, din1, out_ready,
        output in_ready, out_valid, quot, rem, dbz, ovf
    );

endinterface

// File: rtl/myproject_div_sat.sv
// Applies the dividend sign to the magnitude quotient and clips it to the
// signed output range; -2^(Q-1) is representable and does not flag overflow.
module myproject_div_sat
    import myproject_div_pkg::*;
(
    input  logic                              sign,
    input  logic        [DIVIDEND_WIDTH-1:0]  mag,
    output logic signed [QUOTIENT_WIDTH-1:0]  quot,
    output logic                              ovf
);

    always_comb begin
        quot = '0;
        ovf  = 1'b0;
        if (!sign) begin
            if (mag > DIVIDEND_WIDTH'(QMAX_MAG)) begin
                quot = QMAX;
                ovf  = 1'b1;
            end else begin
                quot = mag[QUOTIENT_WIDTH-1:0];
            end
        end else begin
            if (mag > DIVIDEND_WIDTH'(QMIN_MAG)) begin
                quot = QMIN;
                ovf  = 1'b1;
            end else begin
                quot = -mag[QUOTIENT_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/myproject_sdiv_26s_12ns_14_seq.sv
// Radix-2 restoring signed-by-unsigned divider, one quotient bit per clock.
//   state | meaning
//   IDLE  | ready for operands (in_ready high)
//   CALC  | shift/subtract, DIVIDEND_WIDTH cycles
//   DONE  | result valid, held until out_ready
module myproject_sdiv_26s_12ns_14_seq
    import myproject_div_pkg::*;
(
    input logic                             ap_clk,
    input logic                             ap_rst_n,
    myproject_sdiv_26s_12ns_14_seq_if.slave bus
);

    state_t                            state;
    logic                              in_ready_r;
    logic                              out_valid_r;
    logic signed [QUOTIENT_WIDTH-1:0]  quot_r;
    logic signed [DIVISOR_WIDTH:0]     rem_r;
    logic                              dbz_r;
    logic                              ovf_r;

    logic                              sign_r;
    logic        [DIVIDEND_WIDTH-1:0]  mag_r;
    logic        [DIVISOR_WIDTH-1:0]   div_r;
    logic        [DIVISOR_WIDTH-1:0]   prem_r;
    logic        [CNT_WIDTH-1:0]       cnt_r;

    logic        [DIVISOR_WIDTH:0]     trial;
    logic        [DIVISOR_WIDTH:0]     prem_nxt;
    logic                              qbit;
    logic        [DIVIDEND_WIDTH-1:0]  mag_nxt;
    logic signed [QUOTIENT_WIDTH-1:0]  sat_quot;
    logic                              sat_ovf;

    // Quotient bits shift into the low end of the magnitude register as the
    // dividend bits leave the top, so mag_nxt is the quotient after the last step.
    always_comb begin
        trial    = {prem_r, mag_r[DIVIDEND_WIDTH-1]};
        qbit     = (trial >= {1'b0, div_r});
        prem_nxt = qbit ? (trial - {1'b0, div_r}) : trial;
        mag_nxt  = {mag_r[DIVIDEND_WIDTH-2:0], qbit};
    end

    myproject_div_sat u_sat (
        .sign (sign_r),
        .mag  (mag_nxt),
        .quot (sat_quot),
        .ovf  (sat_ovf)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state       <= IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            quot_r      <= '0;
            rem_r       <= '0;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
            sign_r      <= 1'b0;
            mag_r       <= '0;
            div_r       <= '0;
            prem_r      <= '0;
            cnt_r       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_r <= 1'b1;
                    if (bus.in_valid && in_ready_r) begin
                        in_ready_r <= 1'b0;
                        sign_r     <= bus.din0[DIVIDEND_WIDTH-1];
                        mag_r      <= bus.din0[DIVIDEND_WIDTH-1] ? $unsigned(-bus.din0)
                                                                 : $unsigned(bus.din0);
                        div_r      <= bus.din1;
                        prem_r     <= '0;
                        cnt_r      <= CNT_WIDTH'(DIVIDEND_WIDTH - 1);
                        if (bus.din1 == '0) begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                            quot_r      <= bus.din0[DIVIDEND_WIDTH-1] ? QMIN : QMAX;
                            rem_r       <= '0;
                            dbz_r       <= 1'b1;
                            ovf_r       <= 1'b0;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    mag_r  <= mag_nxt;
                    prem_r <= prem_nxt[DIVISOR_WIDTH-1:0];
                    cnt_r  <= cnt_r - 1'b1;
                    if (cnt_r == '0) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                        quot_r      <= sat_quot;
                        ovf_r       <= sat_ovf;
                        dbz_r       <= 1'b0;
                        rem_r       <= sign_r ? -prem_nxt : prem_nxt;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.quot      = quot_r;
    assign bus.rem       = rem_r;
    assign bus.dbz       = dbz_r;
    assign bus.ovf       = ovf_r;

endmodule
